audio_dsm_out: RTL and testbench
================================

Name: audio_dsm_out

Overview:
- Parametrised multi-channel audio output engine. Successor to the fixed 12-bit stereo 44.1 kHz output path.
- Buffers packed PCM frames from an upstream producer in a FIFO with a write handshake. Pops one frame per sample period from an internal clock-enable divider, so no PLL is needed. Each channel drives a first-order delta-sigma 1-bit DAC.
- Reports FIFO level, sticky underrun/overflow flags and a status blink.
- Sits between the sample source (synth/streamer) and the board's RC-filtered DAC pins.

Parameters:
- AUDIO_BITS, 12, PCM width per channel; unsigned offset-binary.
- CHANNELS, 2, number of output channels (≥1); channel 0 = left, 1 = right.
- FIFO_DEPTH, 16, frames buffered; power of 2, ≥2.
- SAMPLE_DIV, 1134, clk cycles per sample period (50 MHz / 44.1 kHz); ≥2.
- DSM_DIV, 1, clk cycles per modulator step; ≥1.
- STATUS_DIV, 50000000, clk cycles per status toggle.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- aclr_  in  1  asynchronous active-low reset.
- wreq  in  1  write request, active high; frame accepted when wreq && !wfull.
- sample  in  CHANNELS*AUDIO_BITS  packed frame; channel k at [k*AUDIO_BITS +: AUDIO_BITS].
- clr_flags  in  1  synchronous clear of underrun/overflow.
- wfull  out  1  FIFO full (level == FIFO_DEPTH).
- level  out  clog2(FIFO_DEPTH)+1  frames currently stored.
- dac_out  out  CHANNELS  registered 1-bit DSM outputs.
- underrun  out  1  sticky: sample tick found FIFO empty.
- overflow  out  1  sticky: wreq asserted while wfull.
- status  out  1  toggles every STATUS_DIV cycles.

Behaviour:
- Reset (aclr_ low, asynchronous):
  - All outputs 0: level=0, wfull=0, dac_out=0, underrun=0, overflow=0, status=0.
  - FIFO pointers, all counters, PCM registers and DSM accumulators cleared.
  - Reset mid-operation discards buffered frames. Release is synchronous to clk via the normal edge.
- FIFO write:
  - On an edge with wreq=1 and wfull=0, sample is stored and level increments (unless a pop occurs on the same edge).
  - wreq=1 with wfull=1: frame dropped, overflow set.
  - No write bypass: a frame written on the same edge as a pop is not the one popped.
- Sample tick:
  - Counter scnt runs 0..SAMPLE_DIV-1, wraps to 0.
  - The edge where scnt==SAMPLE_DIV-1 is a tick; the first tick is the SAMPLE_DIV-th edge after reset release.
  - On a tick with level>0: oldest frame loaded into the per-channel PCM registers, level decrements.
  - On a tick with level==0: PCM registers hold their previous value, underrun set.
- Simultaneous write and pop: level unchanged. wfull is evaluated from the pre-edge level, so a write is refused when full even on a pop edge.
- Flags: clr_flags=1 clears underrun/overflow. If a set event occurs on the same edge, the set wins.
- Delta-sigma modulator (per channel, every DSM_DIV cycles, step enable from its own counter):
  - Accumulator is AUDIO_BITS+1 bits.
  - On each step: acc <= {1'b0, acc[AUDIO_BITS-1:0]} + pcm, and dac_out[k] <= carry of that sum.
  - Over 2^AUDIO_BITS steps with constant pcm, exactly pcm ones are produced.
  - pcm=0 gives constant 0. pcm = 2^AUDIO_BITS-1 gives one 0 per 2^AUDIO_BITS steps.
  - A PCM change takes effect on the next step.
- Status: counter 0..STATUS_DIV-1; status inverts on the wrap edge.
- Widths: no truncation of counters; DSM accumulator wrap is modular by design.

Test Plan:
All scenarios use AUDIO_BITS=4, CHANNELS=2, FIFO_DEPTH=4, SAMPLE_DIV=8, DSM_DIV=1, STATUS_DIV=10.
1. Reset, write frame {ch1=4'hC, ch0=4'h4} at cycle 1 -> level=1. At edge 8 the frame pops, level=0. Over the next 16 steps, dac_out[0] shows 4 ones and dac_out[1] shows 12 ones.
2. Five back-to-back writes after reset -> level reaches 4 and wfull=1. The fifth write is dropped and overflow=1. Pops return frames 1–4 in order.
3. No writes after reset -> first tick at edge 8 sets underrun=1, PCM stays 0, dac_out stays 0. Pulse clr_flags -> underrun=0; the next tick re-sets it.
4. FIFO full, wreq held on a tick edge -> pop occurs, write refused, overflow=1, level=3. Then with level=2, write and tick on the same edge -> level stays 2.
5. Assert aclr_=0 mid-stream with level=3 and dac toggling -> all outputs 0 immediately (asynchronous). After release, level=0 and the first tick is 8 edges later.
6. Run 35 cycles with no traffic -> status toggles at edges 10, 20 and 30 (0→1→0→1).

Source files
------------

// File: rtl/audio_dsm_out.sv
// Multi-channel audio output: frame FIFO, sample-rate divider, per-channel
// first-order delta-sigma 1-bit DACs, sticky error flags and a status blinker.

module audio_dsm_lane #(
  parameter int B = 12
) (
  input  logic         clk,
  input  logic         aclr_,
  input  logic         step_i,
  input  logic [B-1:0] pcm_i,
  output logic         dac_o
);
  logic [B:0] acc_q, acc_d;

  // The top bit of the accumulator is the registered carry, i.e. the DAC bit.
  assign acc_d = {1'b0, acc_q[B-1:0]} + {1'b0, pcm_i};
  assign dac_o = acc_q[B];

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_)      acc_q <= '0;
    else if (step_i) acc_q <= acc_d;
  end
endmodule

module audio_dsm_out #(
  parameter int AUDIO_BITS = 12,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_DIV = 1134,
  parameter int DSM_DIV    = 1,
  parameter int STATUS_DIV = 50000000
) (
  input  logic                             clk,
  input  logic                             aclr_,
  input  logic                             wreq,
  input  logic [CHANNELS*AUDIO_BITS-1:0]   sample,
  input  logic                             clr_flags,
  output logic                             wfull,
  output logic [$clog2(FIFO_DEPTH):0]      level,
  output logic [CHANNELS-1:0]              dac_out,
  output logic                             underrun,
  output logic                             overflow,
  output logic                             status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int DW = (DSM_DIV > 1) ? $clog2(DSM_DIV) : 1;
  localparam int TW = (STATUS_DIV > 1) ? $clog2(STATUS_DIV) : 1;

  typedef logic [CHANNELS*AUDIO_BITS-1:0] frame_t;

  frame_t                                mem_q [FIFO_DEPTH];
  logic [AW-1:0]                         wptr_q, rptr_q;
  logic [AW:0]                           level_q;
  logic [SW-1:0]                         scnt_q;
  logic [DW-1:0]                         dcnt_q;
  logic [TW-1:0]                         tcnt_q;
  logic [CHANNELS-1:0][AUDIO_BITS-1:0]   pcm_q;
  logic                                  und_q, ovf_q, stat_q;
  logic                                  tick, step, push, pop;

  assign wfull = (level_q == (AW+1)'(FIFO_DEPTH));
  assign tick  = (scnt_q == SW'(SAMPLE_DIV - 1));
  assign step  = (dcnt_q == DW'(DSM_DIV - 1));
  assign push  = wreq && !wfull;
  assign pop   = tick && (level_q != '0);

  assign level    = level_q;
  assign underrun = und_q;
  assign overflow = ovf_q;
  assign status   = stat_q;

  // Frame storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= sample;
  end

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pcm_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        pcm_q  <= mem_q[rptr_q];
      end
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      scnt_q <= '0;
      dcnt_q <= '0;
      tcnt_q <= '0;
      stat_q <= 1'b0;
    end else begin
      scnt_q <= tick ? '0 : scnt_q + 1'b1;
      dcnt_q <= step ? '0 : dcnt_q + 1'b1;
      if (tcnt_q == TW'(STATUS_DIV - 1)) begin
        tcnt_q <= '0;
        stat_q <= ~stat_q;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  // Set events take priority over a coincident clear.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      und_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (tick && level_q == '0) und_q <= 1'b1;
      else if (clr_flags)        und_q <= 1'b0;
      if (wreq && wfull)         ovf_q <= 1'b1;
      else if (clr_flags)        ovf_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    audio_dsm_lane #(.B(AUDIO_BITS)) u_lane (
      .clk    (clk),
      .aclr_  (aclr_),
      .step_i (step),
      .pcm_i  (pcm_q[k]),
      .dac_o  (dac_out[k])
    );
  end
endmodule

// File: tb/tb_audio_dsm_out.sv
// Lockstep bench for audio_dsm_out: a queue-based frame model plus modular
// sigma-delta arithmetic is compared against every output after each edge.

module tb_audio_dsm_out;
  localparam int AB = 4, CH = 2, FD = 4, SD = 8, DD = 1, STD = 10;

  logic           clk = 1'b0;
  logic           aclr_ = 1'b0;
  logic           wreq = 1'b0;
  logic [CH*AB-1:0] sample = '0;
  logic           clr_flags = 1'b0;
  logic           wfull;
  logic [$clog2(FD):0] level;
  logic [CH-1:0]  dac_out;
  logic           underrun, overflow, status;

  audio_dsm_out #(
    .AUDIO_BITS(AB), .CHANNELS(CH), .FIFO_DEPTH(FD),
    .SAMPLE_DIV(SD), .DSM_DIV(DD), .STATUS_DIV(STD)
  ) dut (
    .clk(clk), .aclr_(aclr_), .wreq(wreq), .sample(sample),
    .clr_flags(clr_flags), .wfull(wfull), .level(level),
    .dac_out(dac_out), .underrun(underrun), .overflow(overflow),
    .status(status)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  int            n;
  logic [7:0]    q[$];
  int            pcm[CH], acc[CH];
  logic [CH-1:0] m_dac;
  bit            m_und, m_ovf, m_stat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; q.delete(); m_dac = '0; m_und = 0; m_ovf = 0; m_stat = 0;
    for (int k = 0; k < CH; k++) begin pcm[k] = 0; acc[k] = 0; end
  endtask

  task automatic model_edge(input bit w, input logic [7:0] s, input bit c);
    int  sz, sum;
    bit  tick, full;
    logic [7:0] f;
    n++;
    tick = (n % SD) == 0;
    sz   = q.size();
    full = (sz == FD);
    for (int k = 0; k < CH; k++) begin
      sum      = acc[k] + pcm[k];
      m_dac[k] = (sum >= (1 << AB));
      acc[k]   = sum % (1 << AB);
    end
    if (tick && sz > 0) begin
      f = q.pop_front();
      for (int k = 0; k < CH; k++) pcm[k] = (f >> (k*AB)) & ((1 << AB) - 1);
    end
    if (w && !full) q.push_back(s);
    if (tick && sz == 0) m_und = 1; else if (c) m_und = 0;
    if (w && full)       m_ovf = 1; else if (c) m_ovf = 0;
    if ((n % STD) == 0)  m_stat = ~m_stat;
  endtask

  task automatic check_all();
    chk("level",    level,    q.size());
    chk("wfull",    wfull,    q.size() == FD);
    chk("dac_out",  dac_out,  m_dac);
    chk("underrun", underrun, m_und);
    chk("overflow", overflow, m_ovf);
    chk("status",   status,   m_stat);
  endtask

  task automatic step(input bit w, input logic [7:0] s, input bit c);
    wreq = w; sample = s; clr_flags = c;
    @(posedge clk);
    model_edge(w, s, c);
    #1;
    check_all();
    wreq = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(0, '0, 0);
  endtask

  task automatic rst();
    aclr_ = 1'b0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_dac", dac_out, 0);
    chk("rst_flags", {underrun, overflow, status}, 0);
    model_reset();
    @(negedge clk);
    aclr_ = 1'b1;
  endtask

  int ones0, ones1;

  initial begin
    model_reset();
    @(negedge clk);

    // 1: single frame, pop at edge 8, DSM duty 4/16 and 12/16
    rst();
    step(1, 8'hC4, 0);
    chk("s1_level1", level, 1);
    idle(7);
    chk("s1_popped", level, 0);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 0);
      ones0 += dac_out[0];
      ones1 += dac_out[1];
    end
    chk("s1_ones_ch0", ones0, 4);
    chk("s1_ones_ch1", ones1, 12);

    // 2: five writes into depth-4 FIFO, ordered pops
    rst();
    for (int i = 1; i <= 5; i++) step(1, 8'((i + 8) << 4 | i), 0);
    chk("s2_full", wfull, 1);
    chk("s2_ovf", overflow, 1);
    idle(40);
    chk("s2_drained", level, 0);

    // 3: underrun, clear, re-set
    rst();
    idle(8);
    chk("s3_und", underrun, 1);
    chk("s3_dac", dac_out, 0);
    step(0, '0, 1);
    chk("s3_clr", underrun, 0);
    idle(7);
    chk("s3_reset", underrun, 1);

    // 4: write refused on a pop edge when full; write+pop keeps level
    rst();
    for (int i = 0; i < 8; i++) step(1, 8'h5A + 8'(i), 0);
    chk("s4_lvl3", level, 3);
    chk("s4_ovf", overflow, 1);
    idle(8);
    chk("s4_lvl2", level, 2);
    idle(7);
    step(1, 8'h3C, 0);
    chk("s4_wr_pop", level, 2);

    // 5: asynchronous reset mid-stream, then tick timing from release
    rst();
    for (int i = 0; i < 4; i++) step(1, 8'hB7, 0);
    idle(10);
    chk("s5_lvl3", level, 3);
    rst();
    idle(7);
    chk("s5_no_tick_yet", underrun, 0);
    step(0, '0, 0);
    chk("s5_tick8", underrun, 1);

    // 6: status blink
    rst();
    idle(10); chk("s6_st10", status, 1);
    idle(10); chk("s6_st20", status, 0);
    idle(10); chk("s6_st30", status, 1);
    idle(5);

    // randomized traffic in phases of varying write density
    rst();
    for (int ph = 0; ph < 8; ph++) begin
      int pct;
      pct = (ph % 4 == 0) ? 5 : (ph % 4 == 1) ? 20 : (ph % 4 == 2) ? 60 : 95;
      for (int i = 0; i < 200; i++)
        step($urandom_range(99) < pct, 8'($urandom), $urandom_range(19) == 0);
      if (ph == 3) rst();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
